alu_issue_ctrl: RTL and testbench

Control and writeback sequencer that drives the 8-bit ALU from the issuing side. It accepts one 16-bit instruction per valid/ready handshake and decodes it. It presents the operands, opcode and carry-in to the ALU, waits for the ALU to settle, then writes the ALU result into a 4 x 8-bit register file and updates a carry flag. It sits between the instruction source and the ALU in the single-cycle processor datapath.

---
 rtl/alu_issue_ctrl.sv | 171 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue-side control and writeback sequencer for the 8-bit ALU.
// Accepts one 16-bit instruction per valid/ready handshake and decodes it.
// Drives the ALU operands, opcode and carry-in, then waits ALU_LATENCY cycles.
// Writes the ALU result into a 4 x 8-bit register file and updates a carry flag.
// Ports:
//   clk, reset (async, active-high)
//   instr_valid/instr_ready/instr : instruction handshake
//   alu_x/alu_y/alu_carry_in/alu_opcode : registered ALU controls
//   alu_result/alu_overflow : ALU response, sampled in WB
//   busy/done/illegal : status; carry_flag : registered carry
//   dbg_addr/dbg_data : combinational register-file read
module alu_issue_ctrl #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    output logic        alu_carry_in,
    output logic [2:0]  alu_opcode,
    input  logic [7:0]  alu_result,
    input  logic        alu_overflow,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        carry_flag,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [3:0] LAT    = 4'(ALU_LATENCY);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_instr;
    logic [3:0]  r_cnt;
    logic [7:0]  r_regs [4];
    logic [7:0]  r_alu_x;
    logic [7:0]  r_alu_y;
    logic        r_alu_cin;
    logic [2:0]  r_alu_op;
    logic        r_carry;

    logic [2:0]  w_op;
    logic        w_use_c;
    logic        w_imm_sel;
    logic        w_rsv;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [7:0]  w_imm;
    logic [7:0]  w_src;
    logic        w_illegal;
    logic        w_upd_c;

    assign w_op      = r_instr[15:13];
    assign w_use_c   = r_instr[12];
    assign w_imm_sel = r_instr[11];
    assign w_rsv     = r_instr[10];
    assign w_rd      = r_instr[9:8];
    assign w_rs      = r_instr[7:6];
    assign w_imm     = r_instr[7:0];

    assign w_src     = w_imm_sel ? w_imm : r_regs[w_rs];
    assign w_illegal = (w_op > OP_SUB) | w_rsv;
    // Only arithmetic ops produce a meaningful carry out.
    assign w_upd_c   = (w_op == OP_ADD) | (w_op == OP_SUB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (instr_valid) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = w_illegal ? S_IDLE : S_EXEC;
            end
            S_EXEC: begin
                // Leave on the last counted cycle; <= also guards a zero count.
                if (r_cnt <= 4'd1) begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr   <= '0;
            r_cnt     <= '0;
            r_alu_x   <= '0;
            r_alu_y   <= '0;
            r_alu_cin <= 1'b0;
            r_alu_op  <= OP_MOV;
            r_carry   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                    end
                end
                S_DECODE: begin
                    if (!w_illegal) begin
                        r_alu_x   <= r_regs[w_rd];
                        r_alu_y   <= w_src;
                        r_alu_op  <= w_op;
                        r_alu_cin <= (w_op == OP_ADD) & w_use_c & r_carry;
                        r_cnt     <= LAT;
                    end
                end
                S_EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WB: begin
                    r_regs[w_rd] <= alu_result;
                    if (w_upd_c) begin
                        r_carry <= alu_overflow;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign instr_ready  = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_WB);
    assign illegal      = (r_state == S_DECODE) & w_illegal;
    assign alu_x        = r_alu_x;
    assign alu_y        = r_alu_y;
    assign alu_opcode   = r_alu_op;
    assign alu_carry_in = r_alu_cin;
    assign carry_flag   = r_carry;
    assign dbg_data     = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU attached.
// Stimulus pushes hand-computed expectations; a monitor checks DUT outputs.
module tb_alu_issue_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [7:0]  alu_x;
    logic [7:0]  alu_y;
    logic        alu_carry_in;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_result;
    logic        alu_overflow;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        carry_flag;
    logic [1:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;

    alu_issue_ctrl #(.ALU_LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_carry_in(alu_carry_in),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .alu_overflow(alu_overflow),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .carry_flag  (carry_flag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU driven by the DUT.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum      = '0;
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_opcode)
            3'b000: alu_result = alu_y;
            3'b001: begin
                alu_sum      = {1'b0, alu_x} + {1'b0, alu_y} + {8'd0, alu_carry_in};
                alu_result   = alu_sum[7:0];
                alu_overflow = alu_sum[8];
            end
            3'b010: alu_result = alu_x & alu_y;
            3'b011: alu_result = alu_x | alu_y;
            3'b100: begin
                alu_sum      = {1'b0, ~alu_x} + {1'b0, alu_y} + 9'd1;
                alu_result   = alu_sum[7:0];
                alu_overflow = alu_sum[8];
            end
            default: alu_result = '0;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         ill;
        logic [1:0] rd;
        logic [2:0] op;
        logic [7:0] ex;
        logic [7:0] ey;
        logic       ecin;
        logic [7:0] er;
        logic       ec;
        int         hs;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: all comparisons live here.
    initial begin : monitor
        exp_t cur;
        bit   rst_seen = 1'b0;
        bit   rdy_chk = 1'b0;
        int   lowrun = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend    = 1'b0;
                rdy_chk = 1'b0;
                lowrun  = 0;
                if (!rst_seen) begin
                    rst_seen = 1'b1;
                    chk("rst_ready", 32'(instr_ready), 1);
                    chk("rst_busy", 32'(busy), 0);
                    chk("rst_done", 32'(done), 0);
                    chk("rst_illegal", 32'(illegal), 0);
                    chk("rst_carry", 32'(carry_flag), 0);
                    chk("rst_alu", {alu_x, alu_y, 4'(alu_opcode), 4'(alu_carry_in)}, 0);
                    for (int i = 0; i < 4; i++) begin
                        dbg_addr = 2'(i);
                        #1;
                        chk("rst_reg", 32'(dbg_data), 0);
                    end
                end
            end else begin
                rst_seen = 1'b0;
                lowrun = instr_ready ? 0 : lowrun + 1;
                if (pend) begin
                    pend = 1'b0;
                    chk("wb_value", 32'(dbg_data), 32'(cur.er));
                    chk("wb_carry", 32'(carry_flag), 32'(cur.ec));
                    chk("wb_ready", 32'(instr_ready), 1);
                end
                if (rdy_chk) begin
                    rdy_chk = 1'b0;
                    chk("ill_ready", 32'(instr_ready), 1);
                end
                if (done || illegal) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", {30'd0, done, illegal}, 0);
                    end else begin
                        cur = q.pop_front();
                        if (cur.ill) begin
                            chk("ill_kind", {30'd0, done, illegal}, 1);
                            chk("ill_lat", 32'(cyc - cur.hs), 1);
                            chk("ill_lowrun", 32'(lowrun), 1);
                            rdy_chk = 1'b1;
                        end else begin
                            chk("done_kind", {30'd0, done, illegal}, 2);
                            chk("done_lat", 32'(cyc - cur.hs), 32'(2 + LAT));
                            chk("busy_run", 32'(lowrun), 32'(2 + LAT));
                            chk("alu_x", 32'(alu_x), 32'(cur.ex));
                            chk("alu_y", 32'(alu_y), 32'(cur.ey));
                            chk("alu_op", 32'(alu_opcode), 32'(cur.op));
                            chk("alu_cin", 32'(alu_carry_in), 32'(cur.ecin));
                            dbg_addr = cur.rd;
                            #1;
                            // Register still holds the old value (= x) during WB.
                            chk("wb_old", 32'(dbg_data), 32'(cur.ex));
                            pend = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic [15:0] w, input bit push, input bit ill,
                         input logic [7:0] ex, input logic [7:0] ey,
                         input logic ecin, input logic [7:0] er, input logic ec);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready) begin
            n++;
            if (n > 100) begin
                $display("FAIL handshake_timeout: instr %h never accepted", w);
                $fatal(1, "handshake timeout");
            end
            @(negedge clk);
        end
        if (push) begin
            e.ill  = ill;
            e.rd   = w[9:8];
            e.op   = w[15:13];
            e.ex   = ex;
            e.ey   = ey;
            e.ecin = ecin;
            e.er   = er;
            e.ec   = ec;
            e.hs   = cyc;
            q.push_back(e);
        end
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // MOV immediate.
        issue(16'h09A2, 1, 0, 8'h00, 8'hA2, 0, 8'hA2, 0);
        // ADD overflow then ADC.
        issue(16'h08A2, 1, 0, 8'h00, 8'hA2, 0, 8'hA2, 0);
        issue(16'h2880, 1, 0, 8'hA2, 8'h80, 0, 8'h22, 1);
        issue(16'h3840, 1, 0, 8'h22, 8'h40, 1, 8'h63, 0);
        // SUB: y - x.
        issue(16'h0A22, 1, 0, 8'h00, 8'h22, 0, 8'h22, 0);
        issue(16'h8AE0, 1, 0, 8'h22, 8'hE0, 0, 8'hBE, 1);
        // Register-source AND/OR; low bits of the rs byte are junk.
        issue(16'h0922, 1, 0, 8'hA2, 8'h22, 0, 8'h22, 1);
        issue(16'h0BE2, 1, 0, 8'h00, 8'hE2, 0, 8'hE2, 1);
        issue(16'h41C5, 1, 0, 8'h22, 8'hE2, 0, 8'h22, 1);
        issue(16'h0923, 1, 0, 8'h22, 8'h23, 0, 8'h23, 1);
        issue(16'h0BA0, 1, 0, 8'hE2, 8'hA0, 0, 8'hA0, 1);
        issue(16'h61C0, 1, 0, 8'h23, 8'hA0, 0, 8'hA3, 1);
        // use_c on a non-ADD op must not drive carry-in.
        issue(16'h7800, 1, 0, 8'h63, 8'h00, 0, 8'h63, 1);
        // Illegal: op 110, reserved bit, op 101, op 111.
        issue(16'hC8FF, 1, 1, 8'h00, 8'h00, 0, 8'h00, 0);
        issue(16'h0C55, 1, 1, 8'h00, 8'h00, 0, 8'h00, 0);
        issue(16'hA000, 1, 1, 8'h00, 8'h00, 0, 8'h00, 0);
        issue(16'hE3FF, 1, 1, 8'h00, 8'h00, 0, 8'h00, 0);
        // State untouched: R0 still 0x63, carry still 1.
        issue(16'h6800, 1, 0, 8'h63, 8'h00, 0, 8'h63, 1);
        issue(16'h3B00, 1, 0, 8'hA0, 8'h00, 1, 8'hA1, 0);

        // Reset during EXEC discards the in-flight MOV.
        issue(16'h0A55, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(16'h6800, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
        issue(16'h6900, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
        issue(16'h6A00, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
        issue(16'h6B00, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0);
        issue(16'h0A5A, 1, 0, 8'h00, 8'h5A, 0, 8'h5A, 0);
        issue(16'h3A01, 1, 0, 8'h5A, 8'h01, 0, 8'h5B, 0);

        n = 0;
        while (q.size() != 0 || pend) begin
            n++;
            if (n > 200) begin
                $display("FAIL drain_timeout: %0d responses never seen", q.size());
                $fatal(1, "drain timeout");
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
